// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings (control unit,
// instruction memory, decode). Clock and reset stay outside as plain ports.
interface fetch_stage_if #(
    parameter int CNT_W = 16
);
    // Irdy is a one-sided valid: Inst_in is only meaningful when Irdy=1. There
    // is no back-pressure toward memory; the fetch stage re-presents the same PC
    // until Irdy=1 meets STALL=1, or until a redirect changes the PC.
    logic             STALL;
    logic             Condep;
    logic [1:0]       Pcsrc;
    logic [31:0]      Btarget;
    logic [31:0]      Jtarget;
    logic [31:0]      Inst_in;
    logic             Irdy;
    logic [31:0]      PC;
    logic [31:0]      D_Inst;
    logic [31:0]      D_PC4;
    logic             D_Valid;
    logic [CNT_W-1:0] Stall_cnt;
    logic [CNT_W-1:0] Flush_cnt;
    logic [CNT_W-1:0] Bubble_cnt;

    modport master (
        output STALL, Condep, Pcsrc, Btarget, Jtarget, Inst_in, Irdy,
        input  PC, D_Inst, D_PC4, D_Valid, Stall_cnt, Flush_cnt, Bubble_cnt
    );

    modport slave (
        input  STALL, Condep, Pcsrc, Btarget, Jtarget, Inst_in, Irdy,
        output PC, D_Inst, D_PC4, D_Valid, Stall_cnt, Flush_cnt, Bubble_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with next-PC select, IF/ID pipeline
// register honouring stall/cancel/bubble, and saturating hazard counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic          Clk,
    input  logic          Clrn,
    fetch_stage_if.slave  fif
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0]      pc_plus4;
    logic             bubble_cycle;

    assign pc_plus4     = pc_q + 32'd4;
    assign bubble_cycle = !fif.Irdy && fif.STALL && fif.Condep;

    // Redirects win over stall and memory wait; Pcsrc=01 is decoded as a jump.
    always_comb begin
        pc_d = pc_q;
        if (fif.Pcsrc == 2'b10) begin
            pc_d = {fif.Btarget[31:2], 2'b00};
        end else if (fif.Pcsrc[0]) begin
            pc_d = {fif.Jtarget[31:2], 2'b00};
        end else if (fif.STALL && fif.Irdy) begin
            pc_d = pc_plus4;
        end
    end

    // Cancel outranks stall; a bubble leaves D_PC4 at its last value.
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (!fif.Condep) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!fif.STALL) begin
            inst_d  = inst_q;
        end else if (!fif.Irdy) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else begin
            inst_d  = fif.Inst_in;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!fif.STALL && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (!fif.Condep && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
        if (bubble_cycle && bubble_cnt_q != CNT_MAX) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fif.PC         = pc_q;
    assign fif.D_Inst     = inst_q;
    assign fif.D_PC4      = pc4_q;
    assign fif.D_Valid    = valid_q;
    assign fif.Stall_cnt  = stall_cnt_q;
    assign fif.Flush_cnt  = flush_cnt_q;
    assign fif.Bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset/saturation sequences,
// and randomized traffic against a rule-level reference model.
module tb_fetch_stage;
    logic clk;
    logic clrn;
    int   n_vec;
    int   n_miss;

    fetch_stage_if #(.CNT_W(16)) fif ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000),
        .CNT_W    (16)
    ) dut (
        .Clk  (clk),
        .Clrn (clrn),
        .fif  (fif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        condep;
        logic [1:0]  pcsrc;
        logic [31:0] btarget;
        logic [31:0] jtarget;
        logic [31:0] inst;
        logic        irdy;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_scnt;
        logic [15:0] e_fcnt;
        logic [15:0] e_bcnt;
    } vec_t;

    vec_t vecs[18];

    // reference model state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid;
    int          m_scnt, m_fcnt, m_bcnt;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic stall, input logic condep, input logic [1:0] pcsrc,
                         input logic [31:0] bt, input logic [31:0] jt,
                         input logic [31:0] inst, input logic irdy);
        fif.STALL   = stall;
        fif.Condep  = condep;
        fif.Pcsrc   = pcsrc;
        fif.Btarget = bt;
        fif.Jtarget = jt;
        fif.Inst_in = inst;
        fif.Irdy    = irdy;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic valid,
                             input int sc, input int fc, input int bc);
        check({tag, ".PC"},         fif.PC, pc);
        check({tag, ".D_Inst"},     fif.D_Inst, inst);
        check({tag, ".D_PC4"},      fif.D_PC4, pc4);
        check({tag, ".D_Valid"},    {31'd0, fif.D_Valid}, {31'd0, valid});
        check({tag, ".Stall_cnt"},  {16'd0, fif.Stall_cnt}, sc);
        check({tag, ".Flush_cnt"},  {16'd0, fif.Flush_cnt}, fc);
        check({tag, ".Bubble_cnt"}, {16'd0, fif.Bubble_cnt}, bc);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 2'b00, 32'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        clrn = 1'b1;
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_scnt = 0; m_fcnt = 0; m_bcnt = 0;
        @(posedge clk);
        #1;
        m_pc = 32'h4; m_inst = fif.Inst_in; m_pc4 = 32'h4; m_valid = 1'b1;
    endtask

    // Reference model: apply the fetch rules to the current inputs for one edge.
    task automatic model_step();
        logic [31:0] nxt;
        if (fif.Pcsrc == 2'b10)      nxt = fif.Btarget & 32'hFFFF_FFFC;
        else if (fif.Pcsrc != 2'b00) nxt = fif.Jtarget & 32'hFFFF_FFFC;
        else if (!fif.STALL || !fif.Irdy) nxt = m_pc;
        else                         nxt = m_pc + 32'd4;

        if (!fif.Condep) begin
            m_inst = 32'h0; m_valid = 1'b0;
        end else if (fif.STALL && !fif.Irdy) begin
            m_inst = 32'h0; m_valid = 1'b0;
        end else if (fif.STALL) begin
            m_inst = fif.Inst_in; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end

        if (!fif.STALL)  m_scnt = (m_scnt + 1 > 65535) ? 65535 : m_scnt + 1;
        if (!fif.Condep) m_fcnt = (m_fcnt + 1 > 65535) ? 65535 : m_fcnt + 1;
        if (fif.STALL && fif.Condep && !fif.Irdy) m_bcnt = (m_bcnt + 1 > 65535) ? 65535 : m_bcnt + 1;
        m_pc = nxt;
    endtask

    function automatic vec_t mk(logic s, logic c, logic [1:0] p, logic [31:0] bt, logic [31:0] jt,
                                logic [31:0] in, logic r, logic [31:0] pc, logic [31:0] di,
                                logic [31:0] d4, logic v, logic [15:0] sc, logic [15:0] fc,
                                logic [15:0] bc);
        vec_t t;
        t.stall = s; t.condep = c; t.pcsrc = p; t.btarget = bt; t.jtarget = jt;
        t.inst = in; t.irdy = r; t.e_pc = pc; t.e_inst = di; t.e_pc4 = d4;
        t.e_valid = v; t.e_scnt = sc; t.e_fcnt = fc; t.e_bcnt = bc;
        return t;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        n_vec = 0;
        n_miss = 0;
        clrn = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 32'd0, 32'd0, 32'd0, 1'b1);

        // Edge-by-edge table from reset; expected values derived by hand.
        //            S     C     Pcsrc  Btarget        Jtarget        Inst_in        Irdy  PC             D_Inst         D_PC4          V     Sc  Fc  Bc
        vecs[0]  = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'h2001_0005, 1'b1, 32'h8,         32'h2001_0005, 32'h8,         1'b1, 0,  0,  0);
        vecs[1]  = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'h2001_0005, 1'b1, 32'hC,         32'h2001_0005, 32'hC,         1'b1, 0,  0,  0);
        vecs[2]  = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'h2001_0005, 1'b1, 32'h10,        32'h2001_0005, 32'h10,        1'b1, 0,  0,  0);
        vecs[3]  = mk(1'b0, 1'b1, 2'b00, 32'h0,         32'h0,         32'h1111_1111, 1'b1, 32'h10,        32'h2001_0005, 32'h10,        1'b1, 1,  0,  0);
        vecs[4]  = mk(1'b0, 1'b1, 2'b00, 32'h0,         32'h0,         32'h1111_1111, 1'b1, 32'h10,        32'h2001_0005, 32'h10,        1'b1, 2,  0,  0);
        vecs[5]  = mk(1'b1, 1'b0, 2'b10, 32'h0000_0043, 32'h0,         32'h2222_2222, 1'b1, 32'h40,        32'h0,         32'h10,        1'b0, 2,  1,  0);
        vecs[6]  = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'h3333_3333, 1'b1, 32'h44,        32'h3333_3333, 32'h44,        1'b1, 2,  1,  0);
        vecs[7]  = mk(1'b0, 1'b1, 2'b11, 32'h0,         32'h0000_0100, 32'h4444_4444, 1'b1, 32'h100,       32'h3333_3333, 32'h44,        1'b1, 3,  1,  0);
        vecs[8]  = mk(1'b1, 1'b1, 2'b01, 32'h0,         32'h0000_0023, 32'h5555_5555, 1'b1, 32'h20,        32'h5555_5555, 32'h104,       1'b1, 3,  1,  0);
        vecs[9]  = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0, 32'h20,        32'h0,         32'h104,       1'b0, 3,  1,  1);
        vecs[10] = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0, 32'h20,        32'h0,         32'h104,       1'b0, 3,  1,  2);
        vecs[11] = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0, 32'h20,        32'h0,         32'h104,       1'b0, 3,  1,  3);
        vecs[12] = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'h6666_6666, 1'b1, 32'h24,        32'h6666_6666, 32'h24,        1'b1, 3,  1,  3);
        vecs[13] = mk(1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h9999_9999, 1'b1, 32'h24,        32'h0,         32'h24,        1'b0, 4,  2,  3);
        vecs[14] = mk(1'b1, 1'b1, 2'b11, 32'h0,         32'hFFFF_FFFF, 32'h7777_7777, 1'b1, 32'hFFFF_FFFC, 32'h7777_7777, 32'h28,        1'b1, 4,  2,  3);
        vecs[15] = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'h8888_8888, 1'b1, 32'h0,         32'h8888_8888, 32'h0,         1'b1, 4,  2,  3);
        vecs[16] = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0,         32'hAAAA_AAAA, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 4,  3,  3);
        vecs[17] = mk(1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'hBBBB_BBBB, 1'b1, 32'h4,         32'hBBBB_BBBB, 32'h4,         1'b1, 4,  3,  3);

        do_reset();
        // After the first edge with Inst_in=0 the register holds it at PC+4=4.
        drive(1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 32'h2001_0005, 1'b1);
        check_all("edge1", 32'h4, 32'h0, 32'h4, 1'b1, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].stall, vecs[i].condep, vecs[i].pcsrc, vecs[i].btarget,
                  vecs[i].jtarget, vecs[i].inst, vecs[i].irdy);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_pc4,
                      vecs[i].e_valid, vecs[i].e_scnt, vecs[i].e_fcnt, vecs[i].e_bcnt);
        end

        // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
        @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 32'hCAFE_0001, 1'b1);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check_all("resume", 32'h4, 32'hCAFE_0001, 32'h4, 1'b1, 0, 0, 0);

        // Stall counter saturation at all-ones.
        drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'hCAFE_0002, 1'b1);
        repeat (65535) @(posedge clk);
        #1;
        check("sat_reach.Stall_cnt", {16'd0, fif.Stall_cnt}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        check("sat_hold.Stall_cnt", {16'd0, fif.Stall_cnt}, 32'h0000_FFFF);
        check("sat_hold.PC", fif.PC, 32'h4);
        check("sat_hold.D_Inst", fif.D_Inst, 32'hCAFE_0001);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] ps;
            ps = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3));
            drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 6) != 0), ps,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom,
                  $urandom, $urandom, ($urandom_range(0, 4) != 0));
            model_step();
            @(posedge clk);
            #1;
            check_all("rand", m_pc, m_inst, m_pc4, m_valid, m_scnt, m_fcnt, m_bcnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
